dsp_mac_engine: RTL and testbench
=================================

DSP_MAC_ENGINE -- requirements
Module: dsp_mac_engine

Interface
REQ-001 SHALL have parameter AW, default 18, meaning the signed A operand width.
REQ-002 SHALL have parameter BW, default 18, meaning the signed B and D operand width.
REQ-003 SHALL have parameter PW, default 48, meaning the accumulator and P width; PW SHALL be at least AW+BW+1.
REQ-004 SHALL have parameter NCH, default 4, meaning the number of independent accumulator channels (power of 2, at least 2).
REQ-005 SHALL have parameter ACC_LEN, default 16, meaning the number of products summed per result (at least 1).
REQ-006 Reset is RSTA, asynchronous, active-high; clock is CLK.
REQ-007 SHALL have ports, one per line:
- CLK  in  1  clock
- RSTA  in  1  async reset, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts a beat
- in_ch  in  log2(NCH)  target channel
- A  in  AW  signed multiplicand
- B  in  BW  signed pre-adder operand
- D  in  BW  signed pre-adder operand
- premode  in  2  00: B; 01: D+B; 10: D-B; 11: B
- clr  in  1  discard the channel's partial sum before this beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts a result
- out_ch  out  log2(NCH)  channel of the result
- P  out  PW  signed result
- OVF  out  1  overflow occurred in this result

Function
REQ-008 A beat SHALL be accepted on a rising CLK edge when in_valid and in_ready are both 1.
REQ-009 in_ready SHALL equal (!out_valid || out_ready); when out_valid && !out_ready, all pipeline stages SHALL hold.
REQ-010 Stage 1 SHALL register A, B, D, premode, in_ch and clr.
REQ-011 Stage 2 SHALL register M = A * preadd, with preadd being BW+1 bits signed and the product AW+BW+1 bits signed.
REQ-012 Stage 3 SHALL sign-extend M to PW and add it to acc[ch] (acc[ch] taken as 0 if clr), then increment cnt[ch].
REQ-013 When cnt[ch] reaches ACC_LEN, the sum SHALL load the output register (P, out_ch, OVF, out_valid=1), and acc[ch], cnt[ch] and the overflow flag SHALL clear.
REQ-014 Latency SHALL be 3 cycles from acceptance of the last beat to out_valid=1, absent stalls.
REQ-015 Back-to-back beats to the same channel SHALL accumulate correctly with no bubbles.
REQ-016 Beats to other channels SHALL NOT disturb acc, cnt or the overflow flag of any channel.
REQ-017 out_valid SHALL drop on the edge where out_ready=1 unless a new result loads on the same edge.
REQ-018 With clr=1 and ACC_LEN=1, every beat SHALL produce a result.
REQ-019 Channel overflow flag: sticky, set on signed overflow of any stage-3 add, cleared at result emission.

Reset
REQ-020 RSTA=1 SHALL immediately clear all pipeline valids, acc[], cnt[], overflow flags, out_valid, P, out_ch and OVF.
REQ-021 RSTA asserted mid-accumulation SHALL discard partial sums; the first post-reset result SHALL contain only post-reset beats.
REQ-022 in_ready SHALL be 1 during and after reset.

Configuration
REQ-023 Macro DSP_MAC_SAT_EN defined: on overflow, acc SHALL clamp to signed max (positive) or min (negative) of PW bits and remain clamped for the rest of the accumulation.
REQ-024 Macro DSP_MAC_SAT_EN undefined: acc SHALL wrap modulo 2^PW; OVF SHALL still report overflow.

Structure
REQ-025 Package dsp_mac_pkg SHALL hold the premode enum (PM_B, PM_ADD, PM_SUB) and the helper function for PW-bit signed max/min constants.
REQ-026 Sub-module dsp_mac_mul SHALL implement stages 1-2 (pre-adder plus multiplier with stall enable); accumulation, the channel bank and output handshake SHALL live in dsp_mac_engine.

Verification
REQ-027 NCH=4, ACC_LEN=4, ch0 beats A=3, B=2, premode=00 x4 -> out_valid 3 cycles after the 4th beat, P=24, out_ch=0, OVF=0.
REQ-028 Interleave ch1 (A=1, D=5, B=2, premode=10) and ch2 (A=-2, D=1, B=1, premode=01) x4 each -> ch1 P=12 and ch2 P=-16, each emitted once.
REQ-029 Hold out_ready=0 with a result pending while in_valid=1 -> in_ready=0, P is stable, no beat is lost; on release the accumulation resumes exactly.
REQ-030 PW=24, A=B=max positive x ACC_LEN -> with DSP_MAC_SAT_EN: P=0x7FFFFF, OVF=1; without it: P equals the wrapped sum, OVF=1.
REQ-031 Assert RSTA after 2 of 4 ch3 beats, then send 4 beats of A=1, B=1 -> P=4.
REQ-032 ch0 beat with clr=1 after 3 partial beats -> the result contains only the clr beat and the 3 beats that follow it.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: shared types and constants for the DSP MAC engine.
// Holds the pre-adder mode encoding and helpers that build the PW-bit
// signed max/min constants used when saturation (DSP_MAC_SAT_EN) is built in.
package dsp_mac_pkg;

    // Pre-adder mode; 2'b11 is treated like PM_B by the datapath.
    typedef enum logic [1:0] {
        PM_B   = 2'b00,
        PM_ADD = 2'b01,
        PM_SUB = 2'b10
    } premode_e;

    // Wide enough to hold the constants for any practical PW.
    localparam int SAT_VW = 128;

    // Largest positive value of a pw-bit signed number, zero-extended.
    function automatic logic [SAT_VW-1:0] pw_smax(input int pw);
        return (SAT_VW'(1) << (pw - 1)) - SAT_VW'(1);
    endfunction

    // Most negative value of a pw-bit signed number, as a pw-bit pattern.
    function automatic logic [SAT_VW-1:0] pw_smin(input int pw);
        return SAT_VW'(1) << (pw - 1);
    endfunction

endpackage

// File: rtl/dsp_mac_mul.sv
// dsp_mac_mul: stages 1-2 of the MAC pipeline.
// Stage 1 registers the operands; stage 2 registers A * (pre-added B/D).
// Both stages advance only when en is high so a stalled output holds them.
module dsp_mac_mul
    import dsp_mac_pkg::*;
#(
    parameter int AW  = 18,
    parameter int BW  = 18,
    parameter int CHW = 2
)(
    input  logic              CLK,
    input  logic              RSTA,
    input  logic              en,
    input  logic              in_valid,
    input  logic [CHW-1:0]    in_ch,
    input  logic [AW-1:0]     A,
    input  logic [BW-1:0]     B,
    input  logic [BW-1:0]     D,
    input  logic [1:0]        premode,
    input  logic              clr,
    output logic              m_valid,
    output logic [CHW-1:0]    m_ch,
    output logic              m_clr,
    output logic [AW+BW:0]    m
);
    localparam int MW = AW + BW + 1;

    logic           s1_valid_q, s1_valid_d;
    logic [CHW-1:0] s1_ch_q, s1_ch_d;
    logic [AW-1:0]  s1_a_q, s1_a_d;
    logic [BW-1:0]  s1_b_q, s1_b_d;
    logic [BW-1:0]  s1_d_q, s1_d_d;
    logic [1:0]     s1_pm_q, s1_pm_d;
    logic           s1_clr_q, s1_clr_d;
    logic           m_valid_q, m_valid_d;
    logic [CHW-1:0] m_ch_q, m_ch_d;
    logic           m_clr_q, m_clr_d;
    logic [MW-1:0]  m_q, m_d;

    logic [BW:0]    b_ext_s, d_ext_s, pre_s;
    logic [MW-1:0]  a_wide_s, pre_wide_s, prod_s;

    // Pre-adder, full-width product and next-state for both stages.
    always_comb begin
        b_ext_s = {s1_b_q[BW-1], s1_b_q};
        d_ext_s = {s1_d_q[BW-1], s1_d_q};
        case (premode_e'(s1_pm_q))
            PM_B:    pre_s = b_ext_s;
            PM_ADD:  pre_s = d_ext_s + b_ext_s;
            PM_SUB:  pre_s = d_ext_s - b_ext_s;
            default: pre_s = b_ext_s;
        endcase
        // Both operands sign-extended to MW so the truncated product is exact.
        a_wide_s   = {{(BW+1){s1_a_q[AW-1]}}, s1_a_q};
        pre_wide_s = {{AW{pre_s[BW]}}, pre_s};
        prod_s     = a_wide_s * pre_wide_s;

        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_d_d     = s1_d_q;
        s1_pm_d    = s1_pm_q;
        s1_clr_d   = s1_clr_q;
        m_valid_d  = m_valid_q;
        m_ch_d     = m_ch_q;
        m_clr_d    = m_clr_q;
        m_d        = m_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_ch_d    = in_ch;
            s1_a_d     = A;
            s1_b_d     = B;
            s1_d_d     = D;
            s1_pm_d    = premode;
            s1_clr_d   = clr;
            m_valid_d  = s1_valid_q;
            m_ch_d     = s1_ch_q;
            m_clr_d    = s1_clr_q;
            m_d        = prod_s;
        end else begin
            s1_valid_d = s1_valid_q;
            m_valid_d  = m_valid_q;
        end
    end

    // Stage 1 and stage 2 registers.
    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_d_q     <= '0;
            s1_pm_q    <= 2'b00;
            s1_clr_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_ch_q     <= '0;
            m_clr_q    <= 1'b0;
            m_q        <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_d_q     <= s1_d_d;
            s1_pm_q    <= s1_pm_d;
            s1_clr_q   <= s1_clr_d;
            m_valid_q  <= m_valid_d;
            m_ch_q     <= m_ch_d;
            m_clr_q    <= m_clr_d;
            m_q        <= m_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_ch    = m_ch_q;
    assign m_clr   = m_clr_q;
    assign m       = m_q;

endmodule

// File: rtl/dsp_mac_engine.sv
// dsp_mac_engine: multi-channel pre-add/multiply/accumulate engine.
// Stage 3 adds the product into the channel's accumulator; every ACC_LEN
// products the sum is loaded into the output register.
// Build option: define DSP_MAC_SAT_EN to saturate on overflow instead of wrapping.
module dsp_mac_engine
    import dsp_mac_pkg::*;
#(
    parameter int AW      = 18,
    parameter int BW      = 18,
    parameter int PW      = 48,
    parameter int NCH     = 4,
    parameter int ACC_LEN = 16
)(
    input  logic                      CLK,
    input  logic                      RSTA,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NCH)-1:0]    in_ch,
    input  logic [AW-1:0]             A,
    input  logic [BW-1:0]             B,
    input  logic [BW-1:0]             D,
    input  logic [1:0]                premode,
    input  logic                      clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NCH)-1:0]    out_ch,
    output logic [PW-1:0]             P,
    output logic                      OVF
);
    localparam int CHW = $clog2(NCH);
    localparam int MW  = AW + BW + 1;
    localparam int CW  = $clog2(ACC_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN);
`ifdef DSP_MAC_SAT_EN
    localparam logic [PW-1:0] SMAX = PW'(pw_smax(PW));
    localparam logic [PW-1:0] SMIN = PW'(pw_smin(PW));
`endif

    logic           en_s;
    logic           m_valid_s, m_clr_s;
    logic [CHW-1:0] m_ch_s;
    logic [MW-1:0]  m_s;

    logic [PW-1:0]  acc_q [NCH];
    logic [PW-1:0]  acc_d [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] ovf_q, ovf_d;

    logic           out_valid_q, out_valid_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;
    logic [PW-1:0]  p_q, p_d;
    logic           ovf_out_q, ovf_out_d;

    logic [PW-1:0]  base_acc_s, m_ext_s, sum_s, new_acc_s;
    logic [CW-1:0]  base_cnt_s, new_cnt_s;
    logic           base_ovf_s, add_ovf_s, new_ovf_s;

    // The whole pipeline advances unless a result is waiting on the consumer.
    assign en_s     = !out_valid_q || out_ready;
    assign in_ready = en_s;

    dsp_mac_mul #(
        .AW  (AW),
        .BW  (BW),
        .CHW (CHW)
    ) u_mul (
        .CLK      (CLK),
        .RSTA     (RSTA),
        .en       (en_s),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .A        (A),
        .B        (B),
        .D        (D),
        .premode  (premode),
        .clr      (clr),
        .m_valid  (m_valid_s),
        .m_ch     (m_ch_s),
        .m_clr    (m_clr_s),
        .m        (m_s)
    );

    // Stage 3: accumulate into the addressed channel and load the output on completion.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        p_d         = p_q;
        ovf_out_d   = ovf_out_q;

        // clr discards the channel's partial sum, count and overflow history.
        base_acc_s = m_clr_s ? '0   : acc_q[m_ch_s];
        base_cnt_s = m_clr_s ? '0   : cnt_q[m_ch_s];
        base_ovf_s = m_clr_s ? 1'b0 : ovf_q[m_ch_s];
        m_ext_s    = PW'($signed(m_s));
        sum_s      = base_acc_s + m_ext_s;
        add_ovf_s  = (base_acc_s[PW-1] == m_ext_s[PW-1]) && (sum_s[PW-1] != base_acc_s[PW-1]);
`ifdef DSP_MAC_SAT_EN
        // Once clamped, the accumulator stays put until the result is emitted.
        if (base_ovf_s) begin
            new_acc_s = base_acc_s;
        end else if (add_ovf_s) begin
            new_acc_s = base_acc_s[PW-1] ? SMIN : SMAX;
        end else begin
            new_acc_s = sum_s;
        end
`else
        new_acc_s = sum_s;
`endif
        new_ovf_s = base_ovf_s | add_ovf_s;
        new_cnt_s = base_cnt_s + CW'(1);

        if (en_s) begin
            // Any held result has been taken (or none existed) when en_s is high.
            out_valid_d = 1'b0;
            if (m_valid_s) begin
                if (new_cnt_s == CNT_LAST) begin
                    acc_d[m_ch_s] = '0;
                    cnt_d[m_ch_s] = '0;
                    ovf_d[m_ch_s] = 1'b0;
                    out_valid_d   = 1'b1;
                    out_ch_d      = m_ch_s;
                    p_d           = new_acc_s;
                    ovf_out_d     = new_ovf_s;
                end else begin
                    acc_d[m_ch_s] = new_acc_s;
                    cnt_d[m_ch_s] = new_cnt_s;
                    ovf_d[m_ch_s] = new_ovf_s;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Channel bank and output register.
    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            acc_q       <= '{default: '0};
            cnt_q       <= '{default: '0};
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            p_q         <= '0;
            ovf_out_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            p_q         <= p_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign P         = p_q;
    assign OVF       = ovf_out_q;

endmodule

// File: tb/tb_dsp_mac_engine.sv
// tb_dsp_mac_engine: self-checking bench for dsp_mac_engine.
// Directed scenarios plus randomized traffic checked against an arithmetic
// reference model; a second small-PW instance exercises overflow handling.
module tb_dsp_mac_engine;
    localparam int AW = 18, BW = 18, PW = 48, NCH = 4, ACC_LEN = 4, CHW = 2;
    localparam int AW2 = 11, BW2 = 11, PW2 = 24, NCH2 = 2, ACC2 = 16;
`ifdef DSP_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RSTA;
    logic in_valid, in_ready, clr, out_valid, out_ready, OVF;
    logic [CHW-1:0] in_ch, out_ch;
    logic [AW-1:0] A;
    logic [BW-1:0] B, D;
    logic [1:0] premode;
    logic [PW-1:0] P;

    logic in_valid2, in_ready2, clr2, out_valid2, out_ready2, OVF2;
    logic [0:0] in_ch2, out_ch2;
    logic [AW2-1:0] A2;
    logic [BW2-1:0] B2, D2;
    logic [1:0] premode2;
    logic [PW2-1:0] P2;

    // 100 MHz clock.
    always #5 CLK = ~CLK;

    dsp_mac_engine #(.AW(AW), .BW(BW), .PW(PW), .NCH(NCH), .ACC_LEN(ACC_LEN)) dut (
        .CLK(CLK), .RSTA(RSTA), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .A(A), .B(B), .D(D), .premode(premode), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .P(P), .OVF(OVF));

    dsp_mac_engine #(.AW(AW2), .BW(BW2), .PW(PW2), .NCH(NCH2), .ACC_LEN(ACC2)) dut2 (
        .CLK(CLK), .RSTA(RSTA), .in_valid(in_valid2), .in_ready(in_ready2), .in_ch(in_ch2),
        .A(A2), .B(B2), .D(D2), .premode(premode2), .clr(clr2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_ch(out_ch2), .P(P2), .OVF(OVF2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference model: per-channel running sums in plain integer arithmetic.
    typedef struct { int ch; longint p; bit ovf; } res_t;
    res_t   exp_q[$];
    longint m_acc[NCH];
    int     m_cnt[NCH];
    bit     m_ovf[NCH];

    function automatic longint wrap_pw(input longint v, input int pw);
        longint m;
        longint r;
        m = longint'(1) << pw;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_beat(input int ch, input int a, input int b, input int d,
                                       input int pm, input bit c);
        longint pre, prod, sum, lim;
        bit was_ovf;
        pre  = (pm == 1) ? longint'(d) + b : (pm == 2) ? longint'(d) - b : longint'(b);
        prod = longint'(a) * pre;
        if (c) begin m_acc[ch] = 0; m_cnt[ch] = 0; m_ovf[ch] = 1'b0; end
        lim = longint'(1) << (PW - 1);
        sum = m_acc[ch] + prod;
        was_ovf = m_ovf[ch];
        if (sum >= lim || sum < -lim) m_ovf[ch] = 1'b1;
        if (!(SAT && was_ovf)) begin
            if (sum >= lim)       m_acc[ch] = SAT ? lim - 1 : wrap_pw(sum, PW);
            else if (sum < -lim)  m_acc[ch] = SAT ? -lim    : wrap_pw(sum, PW);
            else                  m_acc[ch] = sum;
        end
        m_cnt[ch]++;
        if (m_cnt[ch] == ACC_LEN) begin
            exp_q.push_back('{ch, m_acc[ch], m_ovf[ch]});
            m_acc[ch] = 0; m_cnt[ch] = 0; m_ovf[ch] = 1'b0;
        end
    endfunction

    int     cyc = 0, last_acc_cyc = 0, rise_cyc = -1;
    bit     acc_now, stall_prev = 1'b0, prev_ov = 1'b0;
    longint p_prev = 0;
    longint res_p[NCH];
    int     res_n[NCH];

    // One clock of traffic on the main instance: drive, then observe handshakes.
    task automatic step(input bit v, input int ch, input int a, input int b, input int d,
                        input int pm, input bit c, input bit ordy);
        res_t e;
        @(negedge CLK);
        in_valid = v; in_ch = ch[CHW-1:0]; A = a[AW-1:0]; B = b[BW-1:0]; D = d[BW-1:0];
        premode = pm[1:0]; clr = c; out_ready = ordy;
        #1;
        cyc++;
        if (stall_prev) begin
            check_eq("stall_hold_valid", longint'(out_valid), 1);
            check_eq("stall_hold_p", longint'($signed(P)), p_prev);
        end
        if (out_valid && !out_ready) check_eq("stall_in_ready", longint'(in_ready), 0);
        if (out_valid && !prev_ov) rise_cyc = cyc;
        acc_now = in_valid && in_ready;
        if (acc_now) begin
            model_beat(ch, a, b, d, pm, c);
            last_acc_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("res_ch", longint'(out_ch), longint'(e.ch));
                check_eq("res_p", longint'($signed(P)), e.p);
                check_eq("res_ovf", longint'(OVF), longint'(e.ovf));
            end
            res_p[out_ch] = longint'($signed(P));
            res_n[out_ch]++;
        end
        stall_prev = out_valid && !out_ready;
        p_prev     = longint'($signed(P));
        prev_ov    = out_valid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTA = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
        #1;
        check_eq("rst_in_ready", longint'(in_ready), 1);
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_p", longint'($signed(P)), 0);
        check_eq("rst_ovf", longint'(OVF), 0);
        check_eq("rst_out_valid2", longint'(out_valid2), 0);
        model_clear();
        stall_prev = 1'b0; prev_ov = 1'b0;
        @(negedge CLK);
        RSTA = 1'b0;
    endtask

    int  n_before, k, stall_cnt;
    bit  seen;
    longint exp2;

    // Test sequence.
    initial begin
        RSTA = 1'b1;
        in_valid = 1'b0; in_ch = '0; A = '0; B = '0; D = '0; premode = 2'b00; clr = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_ch2 = '0; A2 = '0; B2 = '0; D2 = '0; premode2 = 2'b00; clr2 = 1'b0; out_ready2 = 1'b1;
        for (int i = 0; i < NCH; i++) begin res_p[i] = 0; res_n[i] = 0; end
        model_clear();
        #1;
        check_eq("init_in_ready", longint'(in_ready), 1);
        check_eq("init_out_valid", longint'(out_valid), 0);
        do_reset();

        // Basic ch0 sum and latency: 4 x (3*2) = 24.
        for (int i = 0; i < 4; i++) step(1'b1, 0, 3, 2, 0, 0, 1'b0, 1'b1);
        rise_cyc = -1;
        for (int i = 0; i < 10 && rise_cyc < 0; i++) step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        check_eq("lat_3", longint'(rise_cyc - last_acc_cyc), 3);
        check_eq("basic_p", res_p[0], 24);
        check_eq("basic_n", longint'(res_n[0]), 1);
        idle(3);

        // Interleaved channels: ch1 (5-2)*1*4 = 12, ch2 (1+1)*-2*4 = -16.
        n_before = res_n[1] + res_n[2];
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1, 1, 2, 5, 2, 1'b0, 1'b1);
            step(1'b1, 2, -2, 1, 1, 1, 1'b0, 1'b1);
        end
        idle(6);
        check_eq("ilv_ch1_p", res_p[1], 12);
        check_eq("ilv_ch2_p", res_p[2], -16);
        check_eq("ilv_count", longint'(res_n[1] + res_n[2] - n_before), 2);

        // Backpressure: result held while ch1 beats keep arriving.
        for (int i = 0; i < 4; i++) step(1'b1, 0, 1, 1, 0, 0, 1'b0, 1'b0);
        k = 0; stall_cnt = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            step(1'b1, 1, 2, 1, 0, 0, 1'b0, i >= 8);
            if (acc_now) k++;
            if (stall_prev) stall_cnt++;
        end
        check_eq("bp_all_beats_taken", longint'(k), 4);
        check_eq("bp_stall_seen", longint'(stall_cnt > 0), 1);
        idle(8);
        check_eq("bp_ch0_p", res_p[0], 4);
        check_eq("bp_ch1_p", res_p[1], 8);

        // clr discards three partial beats: result = 4 x (1*1).
        for (int i = 0; i < 3; i++) step(1'b1, 0, 5, 1, 0, 0, 1'b0, 1'b1);
        step(1'b1, 0, 1, 1, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1, 1, 0, 0, 1'b0, 1'b1);
        idle(6);
        check_eq("clr_p", res_p[0], 4);

        // Reset in mid-accumulation; post-reset result holds only new beats.
        for (int i = 0; i < 2; i++) step(1'b1, 3, 7, 1, 0, 0, 1'b0, 1'b1);
        do_reset();
        n_before = res_n[3];
        for (int i = 0; i < 4; i++) step(1'b1, 3, 1, 1, 0, 0, 1'b0, 1'b1);
        idle(6);
        check_eq("rst_mid_p", res_p[3], 4);
        check_eq("rst_mid_n", longint'(res_n[3] - n_before), 1);

        // Randomized traffic with random backpressure and occasional clr.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)),
                 int'($urandom_range(0, 262143)) - 131072,
                 int'($urandom_range(0, 262143)) - 131072,
                 int'($urandom_range(0, 262143)) - 131072,
                 int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0);
        end
        idle(10);
        check_eq("rand_drained", longint'(exp_q.size()), 0);

        // Overflow on the PW=24 instance: 16 x (1023*1023) exceeds 2^23-1.
        for (int i = 0; i < ACC2; i++) begin
            @(negedge CLK);
            in_valid2 = 1'b1; in_ch2 = 1'b0; A2 = 11'd1023; B2 = 11'd1023; D2 = 11'd0;
            premode2 = 2'b00; clr2 = (i == 0); out_ready2 = 1'b1;
        end
        @(negedge CLK);
        in_valid2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (out_valid2) seen = 1'b1;
            else @(negedge CLK);
        end
        check_eq("ovf_result_seen", longint'(seen), 1);
        exp2 = SAT ? 64'sd8388607 : wrap_pw(longint'(ACC2) * 1023 * 1023, PW2);
        check_eq("ovf_p", longint'($signed(P2)), exp2);
        check_eq("ovf_flag", longint'(OVF2), 1);
        check_eq("ovf_ch", longint'(out_ch2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
